// File: rtl/mci_mcu_sram_req_arb_if.sv
// rtl/mci_mcu_sram_req_arb_if.sv - CIF request/response bundle used on each side of the MCU SRAM arbiter
interface mci_mcu_sram_req_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dv;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              hold;
  logic [DATA_W-1:0] rdata;
  logic              error;

  modport master (output dv, write, addr, wdata, input  hold, rdata, error);
  modport slave  (input  dv, write, addr, wdata, output hold, rdata, error);
endinterface

// File: rtl/mci_mcu_sram_req_arb.sv
// rtl/mci_mcu_sram_req_arb.sv - LSU/IFU/CLP request arbiter in front of the MCU SRAM controller
// MCI_MCU_SRAM_ARB_RR_EN selects round-robin; default is fixed priority IFU > LSU > CLP.
module mci_mcu_sram_req_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mci_mcu_sram_req_arb_if.slave  lsu_if,
  mci_mcu_sram_req_arb_if.slave  ifu_if,
  mci_mcu_sram_req_arb_if.slave  clp_if,
  mci_mcu_sram_req_arb_if.master sram_if,
  output logic                   mcu_lsu_req_o,
  output logic                   mcu_ifu_req_o,
  output logic                   clp_req_o,
  output logic                   starve_err_o,
  output logic [2:0]             starve_src_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [2:0]      lock_q, lock_d;
  logic [2:0]      dv, wr, arb_gnt, grant, gnt_act;
  logic [CW-1:0]   cnt_q [3];
  logic [CW-1:0]   cnt_d [3];
  logic [2:0]      starve_set;
  logic [2:0]      starve_src_q, starve_src_d;
  logic            starve_err_q, starve_err_d;

  // Port index order everywhere: 0=LSU, 1=IFU, 2=CLP
  assign dv = {clp_if.dv,    ifu_if.dv,    lsu_if.dv};
  assign wr = {clp_if.write, ifu_if.write, lsu_if.write};

`ifdef MCI_MCU_SRAM_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic       complete;

  // ptr_q holds the last completed port; search starts at the one after it
  always_comb begin
    arb_gnt = '0;
    case (ptr_q)
      3'b001: begin
        if      (dv[1]) arb_gnt = 3'b010;
        else if (dv[2]) arb_gnt = 3'b100;
        else if (dv[0]) arb_gnt = 3'b001;
      end
      3'b010: begin
        if      (dv[2]) arb_gnt = 3'b100;
        else if (dv[0]) arb_gnt = 3'b001;
        else if (dv[1]) arb_gnt = 3'b010;
      end
      default: begin
        if      (dv[0]) arb_gnt = 3'b001;
        else if (dv[1]) arb_gnt = 3'b010;
        else if (dv[2]) arb_gnt = 3'b100;
      end
    endcase
  end

  assign complete = (|grant) & ~sram_if.hold;
  assign ptr_d    = complete ? grant : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 3'b100;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    arb_gnt = '0;
    if      (dv[1]) arb_gnt = 3'b010;
    else if (dv[0]) arb_gnt = 3'b001;
    else if (dv[2]) arb_gnt = 3'b100;
  end
`endif

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    grant   = (state_q == LOCKED) ? lock_q : arb_gnt;
    case (state_q)
      IDLE: begin
        if ((|grant) && sram_if.hold) begin
          state_d = LOCKED;
          lock_d  = grant;
        end
      end
      LOCKED: begin
        if (!sram_if.hold) begin
          state_d = IDLE;
          lock_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        lock_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // A locked requester that drops dv stops driving the SRAM request and qualifiers
  assign gnt_act = grant & dv;

  assign sram_if.dv    = |gnt_act;
  assign sram_if.write = |(gnt_act & wr);
  assign sram_if.addr  = ({ADDR_W{gnt_act[0]}} & lsu_if.addr)
                       | ({ADDR_W{gnt_act[1]}} & ifu_if.addr)
                       | ({ADDR_W{gnt_act[2]}} & clp_if.addr);
  assign sram_if.wdata = ({DATA_W{gnt_act[0]}} & lsu_if.wdata)
                       | ({DATA_W{gnt_act[1]}} & ifu_if.wdata)
                       | ({DATA_W{gnt_act[2]}} & clp_if.wdata);

  assign lsu_if.hold  = dv[0] & ~(gnt_act[0] & ~sram_if.hold);
  assign ifu_if.hold  = dv[1] & ~(gnt_act[1] & ~sram_if.hold);
  assign clp_if.hold  = dv[2] & ~(gnt_act[2] & ~sram_if.hold);

  assign lsu_if.rdata = (gnt_act[0] & ~sram_if.hold & ~wr[0]) ? sram_if.rdata : '0;
  assign ifu_if.rdata = (gnt_act[1] & ~sram_if.hold & ~wr[1]) ? sram_if.rdata : '0;
  assign clp_if.rdata = (gnt_act[2] & ~sram_if.hold & ~wr[2]) ? sram_if.rdata : '0;

  assign lsu_if.error = gnt_act[0] & sram_if.error;
  assign ifu_if.error = gnt_act[1] & sram_if.error;
  assign clp_if.error = gnt_act[2] & sram_if.error;

  assign mcu_lsu_req_o = gnt_act[0];
  assign mcu_ifu_req_o = gnt_act[1];
  assign clp_req_o     = gnt_act[2];

  // Saturating wait counters; flag latches on the edge the count reaches the limit
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] && !grant[i])
        cnt_d[i] = (cnt_q[i] == LIMIT_C) ? cnt_q[i] : cnt_q[i] + CW'(1);
      else
        cnt_d[i] = '0;
      starve_set[i] = (cnt_d[i] == LIMIT_C);
    end
    starve_src_d = starve_src_q | starve_set;
    starve_err_d = starve_err_q | (|starve_set);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      starve_src_q <= '0;
      starve_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      starve_src_q <= starve_src_d;
      starve_err_q <= starve_err_d;
    end
  end

  assign starve_src_o = starve_src_q;
  assign starve_err_o = starve_err_q;

endmodule

// File: tb/tb_mci_mcu_sram_req_arb.sv
// tb/tb_mci_mcu_sram_req_arb.sv - directed self-checking bench for mci_mcu_sram_req_arb
module tb_mci_mcu_sram_req_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       mcu_lsu_req, mcu_ifu_req, clp_req, starve_err;
  logic [2:0] starve_src;
  int         n_chk  = 0;
  int         n_pass = 0;

  mci_mcu_sram_req_arb_if #(.ADDR_W(32), .DATA_W(32)) lsu ();
  mci_mcu_sram_req_arb_if #(.ADDR_W(32), .DATA_W(32)) ifu ();
  mci_mcu_sram_req_arb_if #(.ADDR_W(32), .DATA_W(32)) clp ();
  mci_mcu_sram_req_arb_if #(.ADDR_W(32), .DATA_W(32)) sram ();

  mci_mcu_sram_req_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .lsu_if        (lsu),
    .ifu_if        (ifu),
    .clp_if        (clp),
    .sram_if       (sram),
    .mcu_lsu_req_o (mcu_lsu_req),
    .mcu_ifu_req_o (mcu_ifu_req),
    .clp_req_o     (clp_req),
    .starve_err_o  (starve_err),
    .starve_src_o  (starve_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clr();
    lsu.dv = 0; lsu.write = 0; lsu.addr = '0; lsu.wdata = '0;
    ifu.dv = 0; ifu.write = 0; ifu.addr = '0; ifu.wdata = '0;
    clp.dv = 0; clp.write = 0; clp.addr = '0; clp.wdata = '0;
    sram.hold = 0; sram.rdata = '0; sram.error = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  function automatic logic [31:0] quals();
    return {29'd0, clp_req, mcu_ifu_req, mcu_lsu_req};
  endfunction

  initial begin
    rst = 1;
    clr();
    tick();
    do_reset();

    // Reset state
    settle();
    chk("rst_sram_dv", sram.dv, 0);
    chk("rst_quals", quals(), 0);
    chk("rst_holds", {lsu.hold, ifu.hold, clp.hold}, 0);
    chk("rst_starve", {starve_err, starve_src}, 0);

    // LSU read 0x100, two cycles; IFU write arrives during the locked cycle
    lsu.dv = 1; lsu.write = 0; lsu.addr = 32'h100; sram.hold = 1;
    settle();
    chk("rd0_sram_dv", sram.dv, 1);
    chk("rd0_addr", sram.addr, 32'h100);
    chk("rd0_lsu_hold", lsu.hold, 1);
    chk("rd0_quals", quals(), 3'b001);
    tick();
    sram.hold = 0; sram.rdata = 32'hDEADBEEF;
    ifu.dv = 1; ifu.write = 1; ifu.addr = 32'h200; ifu.wdata = 32'h1234_5678;
    settle();
    chk("rd1_sram_dv", sram.dv, 1);
    chk("rd1_addr", sram.addr, 32'h100);
    chk("rd1_lsu_hold", lsu.hold, 0);
    chk("rd1_lsu_rdata", lsu.rdata, 32'hDEADBEEF);
    chk("rd1_ifu_hold", ifu.hold, 1);
    chk("rd1_quals", quals(), 3'b001);
    tick();
    lsu.dv = 0; sram.rdata = '0;
    settle();
    chk("wr2_quals", quals(), 3'b010);
    chk("wr2_addr", sram.addr, 32'h200);
    chk("wr2_wdata", sram.wdata, 32'h1234_5678);
    chk("wr2_write", sram.write, 1);
    chk("wr2_ifu_hold", ifu.hold, 0);
    chk("wr2_lsu_rdata", lsu.rdata, 0);
    tick();
    clr();

    // CLP write with error: completes in one cycle, FSM stays idle
    clp.dv = 1; clp.write = 1; clp.addr = 32'h40; sram.error = 1;
    settle();
    chk("cerr_clp_error", clp.error, 1);
    chk("cerr_clp_hold", clp.hold, 0);
    chk("cerr_other_err", {lsu.error, ifu.error}, 0);
    tick();
    clr();
    lsu.dv = 1; lsu.write = 1; lsu.addr = 32'h44;
    settle();
    chk("cerr_next_quals", quals(), 3'b001);
    chk("cerr_next_hold", lsu.hold, 0);
    chk("cerr_clp_err_off", clp.error, 0);
    tick();
    clr();

    // IFU read with double-ECC on the data phase
    ifu.dv = 1; ifu.write = 0; ifu.addr = 32'h80; sram.hold = 1;
    settle();
    chk("ecc0_ifu_hold", ifu.hold, 1);
    tick();
    sram.hold = 0; sram.error = 1; lsu.dv = 1; lsu.write = 1; lsu.addr = 32'h90;
    settle();
    chk("ecc1_ifu_error", ifu.error, 1);
    chk("ecc1_ifu_hold", ifu.hold, 0);
    chk("ecc1_lsu_hold", lsu.hold, 1);
    chk("ecc1_lsu_error", lsu.error, 0);
    tick();
    ifu.dv = 0; sram.error = 0;
    settle();
    chk("ecc2_quals", quals(), 3'b001);
    chk("ecc2_lsu_hold", lsu.hold, 0);
    tick();
    clr();

    // Reset in cycle 0 of a held read drops the lock
    lsu.dv = 1; lsu.write = 0; lsu.addr = 32'h300; sram.hold = 1; rst = 1;
    tick();
    rst = 0;
    clr();
    settle();
    chk("rlk_holds", {lsu.hold, ifu.hold, clp.hold}, 0);
    chk("rlk_quals", quals(), 0);
    chk("rlk_starve", {starve_err, starve_src}, 0);
    ifu.dv = 1; ifu.write = 1; ifu.addr = 32'h304;
    settle();
    chk("rlk_ifu_granted", quals(), 3'b010);
    tick();
    do_reset();

`ifdef MCI_MCU_SRAM_ARB_RR_EN
    // All three writing continuously: LSU, IFU, CLP, LSU
    lsu.dv = 1; lsu.write = 1; ifu.dv = 1; ifu.write = 1; clp.dv = 1; clp.write = 1;
    settle();
    chk("rr0_quals", quals(), 3'b001);
    tick();
    settle();
    chk("rr1_quals", quals(), 3'b010);
    tick();
    settle();
    chk("rr2_quals", quals(), 3'b100);
    tick();
    settle();
    chk("rr3_quals", quals(), 3'b001);
    chk("rr3_starve", {starve_err, starve_src}, 0);
    tick();
    clr();
`else
    // All three writing continuously: IFU always wins, LSU and CLP starve after 64 cycles
    lsu.dv = 1; lsu.write = 1; ifu.dv = 1; ifu.write = 1; clp.dv = 1; clp.write = 1;
    for (int k = 0; k < 64; k++) begin
      settle();
      if (k % 16 == 0) chk($sformatf("fp%0d_quals", k), quals(), 3'b010);
      if (k == 63) chk("fp63_starve_src", starve_src, 0);
      tick();
    end
    settle();
    chk("fp64_starve_src", starve_src, 3'b101);
    chk("fp64_starve_err", starve_err, 1);
    chk("fp64_ifu_hold", ifu.hold, 0);
    tick();
    clr();
    tick();
    settle();
    chk("sticky_starve", {starve_err, starve_src}, 4'b1101);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mci_mcu_sram_req_arb.md
# mci_mcu_sram_req_arb

Three-way request arbiter sitting directly upstream of the MCU SRAM controller inside MCI. It merges the MCU LSU, MCU IFU and Caliptra AXI-subordinate request streams onto the single CIF request path into the SRAM controller. It drives the matching one-hot privilege qualifiers and routes hold/rdata/error back to the granted requester only. It also keeps the grant locked across two-cycle reads and flags requesters that starve.

## Interface
- ADDR_W, 32, CIF address width
- DATA_W, 32, CIF data width
- STARVE_LIMIT, 64, consecutive cycles a port may wait with dv high before starvation is flagged (>=2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- {lsu,ifu,clp}_dv  in  1 each  request valid; held stable by requester while its hold is high
- {lsu,ifu,clp}_write  in  1 each  1=write, 0=read
- {lsu,ifu,clp}_addr  in  ADDR_W each  byte address
- {lsu,ifu,clp}_wdata  in  DATA_W each  write data
- {lsu,ifu,clp}_hold  out  1 each  stall back to requester
- {lsu,ifu,clp}_rdata  out  DATA_W each  read data, valid on completion cycle
- {lsu,ifu,clp}_error  out  1 each  error response
- sram_dv, sram_write, sram_addr, sram_wdata  out  1/1/ADDR_W/DATA_W  request to SRAM controller
- sram_hold  in  1  downstream stall (high on read request phase)
- sram_rdata  in  DATA_W  downstream read data
- sram_error  in  1  downstream error (filter or double ECC)
- mcu_lsu_req, mcu_ifu_req, clp_req  out  1 each  one-hot qualifier of the granted requester, zero when idle
- starve_err  out  1  sticky starvation flag, cleared only by rst
- starve_src  out  3  sticky per-port starvation bits {clp,ifu,lsu}

## Operation
- FSM: IDLE, LOCKED.
- IDLE: arbitrate among dv-high ports; the winner gets a combinational grant. The sram_* request fields mux the winner; the qualifier for that port is asserted.
- IDLE -> LOCKED when the granted transaction sees sram_hold=1. The grant is registered and locked.
- LOCKED: grant forced to the locked port regardless of other dv. LOCKED -> IDLE on the first cycle with sram_hold=0; that cycle is the completion cycle.
- Completion: any granted cycle with sram_hold=0. On completion the arbitration pointer updates to the granted port.
- Per-port responses:
  - hold_x = dv_x & ~(grant_x & ~sram_hold).
  - rdata_x = grant_x & ~sram_hold & ~write ? sram_rdata : 0.
  - error_x = grant_x & sram_error.
- Non-granted dv-high ports see hold=1, rdata=0, error=0.
- Error with sram_hold=0 completes the transaction; no retry.
- Requester dropping dv while LOCKED is a protocol violation. The lock still releases on sram_hold=0, and the sram_* outputs are zeroed once dv drops.
- Starvation counters, one per port:
  - Width $clog2(STARVE_LIMIT+1), saturating.
  - Increment while dv_x & ~grant_x; clear when grant_x or ~dv_x.
  - On reaching STARVE_LIMIT, set starve_src[x] and starve_err.
- Reset: FSM=IDLE, pointer selects LSU as next-highest, counters=0, starve flags=0.
- All outputs are 0 during and immediately after reset when no dv is present.

## Timing
- Zero-cycle request path: a grant in IDLE drives sram_dv in the same cycle as the requester's dv.
- Write: 1 cycle, completes when sram_hold=0.
- Read: 2 cycles. Cycle 0: grant, sram_hold=1, lock. Cycle 1: locked grant, sram_hold=0, rdata routed.
- Back-to-back: in the cycle after completion, the next winner is granted without a bubble.
- Simultaneous completion and new dv: the pointer update takes effect for the next cycle's arbitration, not the current one.
- Reset asserted while LOCKED returns to IDLE next edge; the in-flight response is dropped.

## Configuration
- MCI_MCU_SRAM_ARB_RR_EN defined: round-robin. Priority starts at the port after the last-completed port, in order LSU -> IFU -> CLP -> LSU.
- Undefined: fixed priority IFU > LSU > CLP. The pointer register is not instantiated. Starvation detection is still active and is the only fairness guard.

## Test plan
- Single LSU read of addr 0x100 with sram_rdata=0xDEADBEEF: sram_dv high 2 cycles, lsu_hold=1 then 0, lsu_rdata=0xDEADBEEF on cycle 1, mcu_lsu_req=1 both cycles.
- LSU read locked, IFU dv asserted in cycle 1: IFU stays held through cycle 1. IFU is granted in cycle 2 and mcu_ifu_req=1 only then.
- All three ports request writes continuously with RR_EN: grants rotate LSU, IFU, CLP, LSU, each one cycle. Without RR_EN: IFU granted every cycle, and LSU sets starve_src[0] after exactly 64 waiting cycles.
- CLP write with sram_error=1: clp_error=1 for one cycle, clp_hold=0, other ports' error=0, and the FSM stays IDLE.
- rst asserted in cycle 0 of a held read: next cycle FSM=IDLE, all hold/qualifier outputs 0, starve flags 0.
- Double-ECC read (sram_error=1 with sram_hold=0 on cycle 1): ifu_error=1 on cycle 1, lock released, and the next request is granted on cycle 2.
